// File: rtl/simd_alu_pkg.sv
// Shared definitions for the SIMD ALU: opcodes, lane encodings, FSM states and lane helpers.
package simd_alu_pkg;

    localparam logic [4:0] ALU_OP_ADD  = 5'd0;
    localparam logic [4:0] ALU_OP_ADC  = 5'd1;
    localparam logic [4:0] ALU_OP_SUB  = 5'd2;
    localparam logic [4:0] ALU_OP_SBC  = 5'd3;
    localparam logic [4:0] ALU_OP_AND  = 5'd4;
    localparam logic [4:0] ALU_OP_ORR  = 5'd5;
    localparam logic [4:0] ALU_OP_EOR  = 5'd6;
    localparam logic [4:0] ALU_OP_MVN  = 5'd7;   // result = ~b
    localparam logic [4:0] ALU_OP_BSWP = 5'd8;
    localparam logic [4:0] ALU_OP_LSL  = 5'd9;
    localparam logic [4:0] ALU_OP_LSR  = 5'd10;
    localparam logic [4:0] ALU_OP_ASR  = 5'd11;
    localparam logic [4:0] ALU_OP_ROR  = 5'd12;
    localparam logic [4:0] ALU_OP_ADDS = 5'd13;
    localparam logic [4:0] ALU_OP_SUBS = 5'd14;

    localparam logic [1:0] LANE_8  = 2'd0;
    localparam logic [1:0] LANE_16 = 2'd1;
    localparam logic [1:0] LANE_32 = 2'd2;
    localparam logic [1:0] LANE_64 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_op_e;

    function automatic logic [6:0] lane_bits(input logic [1:0] lane);
        return 7'd8 << lane;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [6:0] lbits);
        return (lbits == 7'd64) ? '1 : ((64'd1 << lbits) - 64'd1);
    endfunction

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == ALU_OP_LSL) || (op == ALU_OP_LSR) ||
               (op == ALU_OP_ASR) || (op == ALU_OP_ROR);
    endfunction

    function automatic shift_op_e to_shift_op(input logic [4:0] op);
        case (op)
            ALU_OP_LSR: return SH_LSR;
            ALU_OP_ASR: return SH_ASR;
            ALU_OP_ROR: return SH_ROR;
            default:    return SH_LSL;
        endcase
    endfunction

endpackage

// File: rtl/simd_shift_unit.sv
// Per-lane iterative shifter: each EXEC cycle every lane advances by up to SHIFT_STEP positions.
module simd_shift_unit
    import simd_alu_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  shift_op_e           sop_i,
    input  logic [1:0]          lane_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [DATA_W/8-1:0] cout_o,
    output logic                last_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] data_q, data_d;
    logic [NB-1:0]     cout_q, cout_d;
    logic [6:0]        rem_q [NB];
    logic [6:0]        rem_d [NB];
    logic [6:0]        amt   [NB];
    logic [1:0]        lane_q;
    shift_op_e         sop_q;

    function automatic logic [64:0] shift_lane(input logic [63:0] v_in, input logic [6:0] lbits,
                                               input logic [6:0] k, input shift_op_e sop);
        logic [63:0] mask, v, r;
        logic [5:0]  hi_idx, lo_idx, sign_idx;
        logic        c;
        mask     = lane_mask(lbits);
        v        = v_in & mask;
        hi_idx   = 6'(lbits - k);
        lo_idx   = 6'(k - 7'd1);
        sign_idx = 6'(lbits - 7'd1);
        r        = v;
        c        = 1'b0;
        case (sop)
            SH_LSL: begin r = v << k;                          c = v[hi_idx]; end
            SH_LSR: begin r = v >> k;                          c = v[lo_idx]; end
            SH_ASR: begin r = (v | (v[sign_idx] ? ~mask : 64'd0)) >> k; c = v[lo_idx]; end
            SH_ROR: begin r = (v >> k) | (v << (lbits - k));   c = v[lo_idx]; end
            default: ;
        endcase
        return {c, r & mask};
    endfunction

    // Amount per lane is taken from the low log2(lane bits) bits of that lane of b.
    always_comb begin
        logic [6:0] lb;
        lb = lane_bits(lane_i);
        for (int l = 0; l < NB; l++) begin
            amt[l] = '0;
            if (l < (NB >> lane_i)) begin
                amt[l] = 7'(b_i >> (l * int'(lb))) & (lb - 7'd1);
            end
        end
    end

    always_comb begin
        logic [6:0]  lb, k;
        logic [63:0] mask;
        logic [64:0] sres;
        int          sh;
        data_d = data_q;
        cout_d = cout_q;
        lb     = lane_bits(lane_q);
        mask   = lane_mask(lb);
        for (int l = 0; l < NB; l++) begin
            rem_d[l] = rem_q[l];
            k        = '0;
            sh       = 0;
            sres     = '0;
            if (l < (NB >> lane_q)) begin
                k        = (int'(rem_q[l]) > SHIFT_STEP) ? 7'(SHIFT_STEP) : rem_q[l];
                rem_d[l] = rem_q[l] - k;
                sh       = l * int'(lb);
                if (k != '0) begin
                    sres   = shift_lane(64'(data_q >> sh), lb, k, sop_q);
                    data_d = (data_d & ~(DATA_W'(mask) << sh)) | (DATA_W'(sres[63:0]) << sh);
                    cout_d[(l + 1) * int'(lb >> 3) - 1] = sres[64];
                end
            end
        end
    end

    always_comb begin
        last_o = 1'b1;
        for (int l = 0; l < NB; l++) begin
            if (rem_d[l] != '0) last_o = 1'b0;
        end
    end

    assign data_o = data_d;
    assign cout_o = cout_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            cout_q <= '0;
            lane_q <= LANE_8;
            sop_q  <= SH_LSL;
            for (int l = 0; l < NB; l++) rem_q[l] <= '0;
        end else if (load_i) begin
            data_q <= a_i;
            cout_q <= '0;
            lane_q <= lane_i;
            sop_q  <= sop_i;
            for (int l = 0; l < NB; l++) rem_q[l] <= amt[l];
        end else if (step_i) begin
            data_q <= data_d;
            cout_q <= cout_d;
            for (int l = 0; l < NB; l++) rem_q[l] <= rem_d[l];
        end
    end

endmodule

// File: rtl/simd_alu.sv
// SIMD ALU with lane-partitioned add/logic/swap and an iterative shifter behind a valid/ready FSM.
// Define SIMD_ALU_SAT_EN to enable the unsigned saturating ADDS/SUBS opcodes.
module simd_alu
    import simd_alu_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          op,
    input  logic [1:0]          lane,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [DATA_W/8-1:0] cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic [DATA_W/8-1:0] cout,
    output logic                err
);
    localparam int NB = DATA_W / 8;

    alu_state_e        state_q;
    logic [4:0]        op_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [NB-1:0]     cin_q, cout_q;
    logic              err_q, in_ready_q, out_valid_q;

    logic [DATA_W-1:0] add_res, swap_res, alu_res, sh_data;
    logic [NB-1:0]     carry, add_cout, alu_cout, sh_cout;
    logic              alu_err, sh_last;
    logic [3:0]        lbm;

    simd_shift_unit #(
        .DATA_W     (DATA_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == ST_IDLE && in_valid),
        .step_i (state_q == ST_EXEC && is_shift_op(op_q)),
        .sop_i  (to_shift_op(op)),
        .lane_i (lane),
        .a_i    (a),
        .b_i    (b),
        .data_o (sh_data),
        .cout_o (sh_cout),
        .last_o (sh_last)
    );

    // Byte-wise ripple adder; the carry chain restarts at every lane's low byte.
    always_comb begin
        logic       c, inv_b;
        logic [7:0] bb;
        logic [8:0] sum;
        lbm   = 4'((5'd1 << lane_q) - 5'd1);
        inv_b = (op_q == ALU_OP_SUB) || (op_q == ALU_OP_SBC) || (op_q == ALU_OP_SUBS);
        c     = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bb = inv_b ? ~b_q[i*8 +: 8] : b_q[i*8 +: 8];
            if ((4'(i) & lbm) == 4'd0) begin
                if (op_q == ALU_OP_ADC || op_q == ALU_OP_SBC) c = cin_q[i];
                else c = (op_q == ALU_OP_SUB) || (op_q == ALU_OP_SUBS);
            end
            sum               = {1'b0, a_q[i*8 +: 8]} + {1'b0, bb} + {8'd0, c};
            add_res[i*8 +: 8] = sum[7:0];
            carry[i]          = sum[8];
            c                 = sum[8];
        end
        for (int i = 0; i < NB; i++) begin
            add_cout[i]        = ((4'(i) & lbm) == lbm) & carry[i];
            swap_res[i*8 +: 8] = a_q[(i ^ int'(lbm))*8 +: 8];
        end
    end

`ifdef SIMD_ALU_SAT_EN
    logic [DATA_W-1:0] sat_res;
    logic [NB-1:0]     sat_cout;

    // ADDS saturates on lane carry-out; SUBS saturates to 0 when the lane borrows.
    always_comb begin
        logic up, sat;
        up = (op_q == ALU_OP_ADDS);
        for (int i = 0; i < NB; i++) begin
            sat               = up ? carry[i | int'(lbm)] : ~carry[i | int'(lbm)];
            sat_res[i*8 +: 8] = sat ? {8{up}} : add_res[i*8 +: 8];
            sat_cout[i]       = ((4'(i) & lbm) == lbm) & sat;
        end
    end
`endif

    always_comb begin
        alu_res  = '0;
        alu_cout = '0;
        alu_err  = 1'b0;
        case (op_q)
            ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBC: begin
                alu_res  = add_res;
                alu_cout = add_cout;
            end
            ALU_OP_AND:  alu_res = a_q & b_q;
            ALU_OP_ORR:  alu_res = a_q | b_q;
            ALU_OP_EOR:  alu_res = a_q ^ b_q;
            ALU_OP_MVN:  alu_res = ~b_q;
            ALU_OP_BSWP: alu_res = swap_res;
            ALU_OP_LSL, ALU_OP_LSR, ALU_OP_ASR, ALU_OP_ROR: begin
                alu_res  = sh_data;
                alu_cout = sh_cout;
            end
`ifdef SIMD_ALU_SAT_EN
            ALU_OP_ADDS, ALU_OP_SUBS: begin
                alu_res  = sat_res;
                alu_cout = sat_cout;
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= ALU_OP_ADD;
            lane_q      <= LANE_8;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= '0;
            result_q    <= '0;
            cout_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        lane_q     <= lane;
                        a_q        <= a;
                        b_q        <= b;
                        cin_q      <= cin;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!is_shift_op(op_q) || sh_last) begin
                        result_q    <= alu_res;
                        cout_q      <= alu_cout;
                        err_q       <= alu_err;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule
